// File: rtl/factor_search_seq.sv
// Sequential trial-division factorizer: finds the smallest f1 >= 2 with a = f1*f2,
// where both factors fit in N bits, using a restoring shift-subtract divider.
module factor_search_seq #(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] a,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [N-1:0]   f1,
  output logic [N-1:0]   f2
);

  localparam int CW = $clog2(2*N+1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(2*N);
  localparam logic [CW-1:0]  CNT_LAST = CW'(1);
  localparam logic [N:0]     D_START  = (N+1)'(2);
  localparam logic [N:0]     D_MAX    = {1'b0, {N{1'b1}}};
  localparam logic [2*N-1:0] Q_MIN    = (2*N)'(2);
  localparam logic [2*N-1:0] Q_MAX    = {{N{1'b0}}, {N{1'b1}}};
  localparam logic [2*N-1:0] A_ZERO   = '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DIV   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         r_state, w_next;
  logic [2*N-1:0] r_a, r_quo;
  logic [N:0]     r_rem, r_d;
  logic [CW-1:0]  r_cnt;
  logic           r_zero;
  logic           r_ready, r_busy, r_done, r_found;
  logic [N-1:0]   r_f1, r_f2;

  logic [N+1:0]   w_t;
  logic           w_ge;
  logic [N:0]     w_rem_nxt;
  logic           w_exact, w_q_lt_d, w_d_last;

  // One restoring-division step and the candidate verdict terms.
  always_comb begin
    w_t       = {r_rem, r_quo[2*N-1]};
    w_ge      = (w_t >= {1'b0, r_d});
    w_rem_nxt = w_t[N:0];
    if (w_ge) begin
      w_rem_nxt = w_t[N:0] - r_d;
    end else begin
      w_rem_nxt = w_t[N:0];
    end
    w_exact  = (r_rem == '0) && (r_quo >= Q_MIN) && (r_quo <= Q_MAX);
    w_q_lt_d = (r_quo < {{(N-1){1'b0}}, r_d});
    w_d_last = (r_d == D_MAX);
  end

  // Next-state logic; a zero operand short-circuits through CHECK so done lands one cycle after accept.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (a == A_ZERO) ? S_CHECK : S_LOAD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD: w_next = S_DIV;
      S_DIV: begin
        if (r_cnt == CNT_LAST) begin
          w_next = S_CHECK;
        end else begin
          w_next = S_DIV;
        end
      end
      S_CHECK: begin
        if (r_zero || w_exact || w_q_lt_d || w_d_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_LOAD;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, datapath and registered status/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      r_f1    <= '0;
      r_f2    <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      r_busy  <= (w_next == S_LOAD) || (w_next == S_DIV) || (w_next == S_CHECK);
      r_done  <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_d     <= D_START;
            r_zero  <= (a == A_ZERO);
            r_found <= 1'b0;
            r_f1    <= '0;
            r_f2    <= '0;
          end
        end
        S_LOAD: begin
          r_rem <= '0;
          r_quo <= r_a;
          r_cnt <= CNT_INIT;
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[2*N-2:0], w_ge};
          r_cnt <= r_cnt - CNT_LAST;
        end
        S_CHECK: begin
          if (r_zero) begin
            r_found <= 1'b1;
          end else if (w_exact) begin
            r_found <= 1'b1;
            r_f1    <= r_d[N-1:0];
            r_f2    <= r_quo[N-1:0];
          end else if (!w_q_lt_d && !w_d_last) begin
            r_d <= r_d + (N+1)'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign found = r_found;
  assign f1    = r_f1;
  assign f2    = r_f2;

endmodule
